// File: rtl/button_debounce_pair.sv
// Two-channel pushbutton conditioner: synchroniser + debounce FSM per channel, registered rise strobes.
// Optional macro DEBOUNCE_FALL_PULSE_EN adds a_fall/b_fall strobes on 1->0 output changes.

module button_debounce_chan #(
   parameter int SYNC_STAGES  = 2,
   parameter int STABLE_COUNT = 50000,
   parameter int CNT_WIDTH    = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic raw_i,
   output logic level_o,
   output logic pending_o,
`ifdef DEBOUNCE_FALL_PULSE_EN
   output logic fall_o,
`endif
   output logic rise_o
);
   // state   | meaning
   // STABLE  | synchronised input equals output, counter held at 0
   // PENDING | synchronised input differs, counting towards STABLE_COUNT-1
   typedef enum logic {ST_STABLE, ST_PENDING} state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("button_debounce_chan: SYNC_STAGES must be at least 2");
   end
   if (STABLE_COUNT < 1 || longint'(STABLE_COUNT) >= (longint'(1) << CNT_WIDTH)) begin : g_bad_cnt
      $error("button_debounce_chan: STABLE_COUNT must be in 1 .. 2**CNT_WIDTH-1");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_WIDTH-1:0]   cnt_q;
   logic                   level_q;
   logic                   rise_q;
   logic                   fall_q;
   logic                   sync_w;
   state_t                 state_w;

   assign sync_w  = sync_q[SYNC_STAGES-1];
   assign state_w = (sync_w != level_q) ? ST_PENDING : ST_STABLE;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         case (state_w)
            ST_STABLE: cnt_q <= '0;
            ST_PENDING: begin
               if (cnt_q == CNT_LAST) begin
                  level_q <= sync_w;
                  cnt_q   <= '0;
                  rise_q  <= sync_w;
                  fall_q  <= ~sync_w;
               end else begin
                  cnt_q <= cnt_q + CNT_WIDTH'(1);
               end
            end
            default: cnt_q <= '0;
         endcase
      end
   end

   assign level_o   = level_q;
   assign rise_o    = rise_q;
   assign pending_o = (state_w == ST_PENDING);
`ifdef DEBOUNCE_FALL_PULSE_EN
   assign fall_o    = fall_q;
`else
   logic unused_fall_w;
   assign unused_fall_w = fall_q;
`endif
endmodule

module button_debounce_pair #(
   parameter int SYNC_STAGES  = 2,
   parameter int STABLE_COUNT = 50000,
   parameter int CNT_WIDTH    = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_a_raw,
   input  logic btn_b_raw,
   output logic a,
   output logic b,
   output logic a_rise,
   output logic b_rise,
`ifdef DEBOUNCE_FALL_PULSE_EN
   output logic a_fall,
   output logic b_fall,
`endif
   output logic busy
);
   logic pend_a_w;
   logic pend_b_w;
   logic busy_q;

   button_debounce_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_COUNT(STABLE_COUNT),
      .CNT_WIDTH   (CNT_WIDTH)
   ) u_chan_a (
      .clk_i    (clk),
      .rst_i    (rst),
      .raw_i    (btn_a_raw),
      .level_o  (a),
      .pending_o(pend_a_w),
`ifdef DEBOUNCE_FALL_PULSE_EN
      .fall_o   (a_fall),
`endif
      .rise_o   (a_rise)
   );

   button_debounce_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_COUNT(STABLE_COUNT),
      .CNT_WIDTH   (CNT_WIDTH)
   ) u_chan_b (
      .clk_i    (clk),
      .rst_i    (rst),
      .raw_i    (btn_b_raw),
      .level_o  (b),
      .pending_o(pend_b_w),
`ifdef DEBOUNCE_FALL_PULSE_EN
      .fall_o   (b_fall),
`endif
      .rise_o   (b_rise)
   );

   // busy reflects the pending comparison made at the same edge as the channel FSMs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy_q <= 1'b0;
      else     busy_q <= pend_a_w | pend_b_w;
   end

   assign busy = busy_q;
endmodule

// File: tb/tb_button_debounce_pair.sv
// Directed bench for button_debounce_pair (STABLE_COUNT=4, SYNC_STAGES=2); strobes go through a scoreboard.
`timescale 1ns/1ps
module tb_button_debounce_pair;
   logic clk = 1'b0;
   logic rst;
   logic btn_a_raw, btn_b_raw;
   logic a, b, a_rise, b_rise, busy;
`ifdef DEBOUNCE_FALL_PULSE_EN
   logic a_fall, b_fall;
`endif

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      int   cyc;
      logic ar;
      logic br;
   } strobe_t;
   strobe_t exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   button_debounce_pair #(
      .SYNC_STAGES (2),
      .STABLE_COUNT(4),
      .CNT_WIDTH   (16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_a_raw(btn_a_raw),
      .btn_b_raw(btn_b_raw),
      .a        (a),
      .b        (b),
      .a_rise   (a_rise),
      .b_rise   (b_rise),
`ifdef DEBOUNCE_FALL_PULSE_EN
      .a_fall   (a_fall),
      .b_fall   (b_fall),
`endif
      .busy     (busy)
   );

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: every strobe the DUT presents must match the next expected event.
   always @(negedge clk) begin
      if (!rst && (a_rise || b_rise)) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_strobe: a_rise=%b b_rise=%b at cycle %0d, none expected",
                     a_rise, b_rise, cyc);
         end else begin
            strobe_t e;
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.ar !== a_rise || e.br !== b_rise) begin
               failures++;
               $display("FAIL strobe: got cyc=%0d a_rise=%b b_rise=%b expected cyc=%0d a_rise=%b b_rise=%b",
                        cyc, a_rise, b_rise, e.cyc, e.ar, e.br);
            end
         end
      end
   end

   initial begin
      int k;
      rst = 1'b1; btn_a_raw = 1'b0; btn_b_raw = 1'b0;
      tick(3);
      check("reset_a", a, 1'b0);
      check("reset_b", b, 1'b0);
      check("reset_busy", busy, 1'b0);
      check("reset_a_rise", a_rise, 1'b0);
      rst = 1'b0;
      tick(2);

      // 1: single rise on channel A, a=1 after E5
      btn_a_raw = 1'b1; k = cyc;
      exp_q.push_back('{k + 6, 1'b1, 1'b0});
      tick(2);
      check("s1_busy_after_E1", busy, 1'b0);
      tick(1);
      check("s1_busy_after_E2", busy, 1'b1);
      tick(2);
      check("s1_a_after_E4", a, 1'b0);
      tick(1);
      check("s1_a_after_E5", a, 1'b1);
      check("s1_rise_after_E5", a_rise, 1'b1);
      check("s1_busy_after_E5", busy, 1'b1);
      tick(1);
      check("s1_rise_after_E6", a_rise, 1'b0);
      check("s1_busy_after_E6", busy, 1'b0);

      // 2: three-cycle pulse on B is one short of acceptance
      btn_b_raw = 1'b1;
      tick(3);
      btn_b_raw = 1'b0;
      tick(2);
      check("s2_busy_during", busy, 1'b1);
      tick(6);
      check("s2_b_stays_0", b, 1'b0);
      check("s2_busy_clear", busy, 1'b0);

      // 3: bounce on A after returning it to 0
      btn_a_raw = 1'b0;
      tick(8);
      check("s3_a_low", a, 1'b0);
      btn_a_raw = 1'b1; tick(1);
      btn_a_raw = 1'b0; tick(1);
      btn_a_raw = 1'b1; tick(1);
      btn_a_raw = 1'b0; tick(1);
      btn_a_raw = 1'b1; k = cyc;
      exp_q.push_back('{k + 6, 1'b1, 1'b0});
      tick(5);
      check("s3_a_before", a, 1'b0);
      tick(1);
      check("s3_a_after", a, 1'b1);
      tick(2);

      // 4: simultaneous rise on both channels
      btn_a_raw = 1'b0;
      tick(8);
      btn_a_raw = 1'b1; btn_b_raw = 1'b1; k = cyc;
      exp_q.push_back('{k + 6, 1'b1, 1'b1});
      tick(5);
      check("s4_nand_before", ~(a & b), 1'b1);
      tick(1);
      check("s4_a", a, 1'b1);
      check("s4_b", b, 1'b1);
      check("s4_nand_after", ~(a & b), 1'b0);
      tick(2);

      // 5: async reset mid-count, A re-propagates in full after release
      btn_a_raw = 1'b0;
      tick(8);
      btn_a_raw = 1'b1;
      tick(4);
      check("s5_busy_pending", busy, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("s5_rst_a", a, 1'b0);
      check("s5_rst_b", b, 1'b0);
      check("s5_rst_rise", a_rise, 1'b0);
      check("s5_rst_busy", busy, 1'b0);
      tick(2);
      rst = 1'b0; k = cyc;
      exp_q.push_back('{k + 6, 1'b1, 1'b1});
      tick(5);
      check("s5_a_before", a, 1'b0);
      tick(1);
      check("s5_a_after", a, 1'b1);
      check("s5_b_after", b, 1'b1);
      tick(2);

`ifdef DEBOUNCE_FALL_PULSE_EN
      // 6: fall strobe on A
      btn_a_raw = 1'b0;
      tick(5);
      check("s6_a_before", a, 1'b1);
      check("s6_fall_before", a_fall, 1'b0);
      tick(1);
      check("s6_a_after", a, 1'b0);
      check("s6_fall_pulse", a_fall, 1'b1);
      check("s6_b_fall", b_fall, 1'b0);
      check("s6_rise", a_rise, 1'b0);
      tick(1);
      check("s6_fall_end", a_fall, 1'b0);
      tick(2);
`endif

      tick(4);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL missing_strobes: %0d expected strobes never seen, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/button_debounce_pair.md
Name: button_debounce_pair

Overview:
Two-channel input conditioner: synchronises and debounces two raw pushbutton/switch inputs and presents clean levels on a and b to the downstream NAND gate stage. It also produces single-cycle rising-edge strobes per channel for counters and LEDs. It sits between the board I/O pins and the gate-level logic under test.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops per channel; minimum 2.
STABLE_COUNT, 50000, consecutive cycles the synchronised input must differ from the output before the output changes (1 ms at 50 MHz); range 1 to 2^CNT_WIDTH-1.
CNT_WIDTH, 16, width of each channel's stability counter.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst  input  1  asynchronous, active-high reset.
btn_a_raw  input  1  raw, asynchronous, bouncing input for channel A.
btn_b_raw  input  1  raw, asynchronous, bouncing input for channel B.
a  output  1  debounced level for channel A; feeds gate input a.
b  output  1  debounced level for channel B; feeds gate input b.
a_rise  output  1  one-cycle strobe when a changes from 0 to 1.
b_rise  output  1  one-cycle strobe when b changes from 0 to 1.
busy  output  1  high while either channel's synchronised input differs from its output.

Behaviour:
- Reset, applied asynchronously and held while rst=1: all sync flops, counters, a, b, a_rise, b_rise and busy are 0. On release, the first evaluation happens on the next rising clk edge.
- The two channels are identical and fully independent. Channel A is described here.
- Synchroniser: a SYNC_STAGES-deep flop chain on btn_a_raw. Its last stage is sync_a.
- FSM per channel has two states:
  - STABLE (sync_a == a): counter held at 0.
  - PENDING (sync_a != a): on each edge, if cnt == STABLE_COUNT-1, then a <= sync_a, cnt <= 0, state returns to STABLE. Otherwise cnt <= cnt+1.
  - If sync_a returns to equal a while PENDING, cnt <= 0 and the state returns to STABLE with no output change. This is the glitch rejection.
- Latency: a raw change held steady is reflected on a after exactly SYNC_STAGES + STABLE_COUNT rising edges, counting the edge that first samples the new raw value.
- a_rise is registered. It is 1 for exactly the one cycle after the edge on which a goes 0->1, and 0 otherwise. A 1->0 change produces no a_rise.
- busy is registered as (sync_a != a) | (sync_b != b), evaluated at the same edge.
- Simultaneous changes on both channels are handled independently. Both outputs may change on the same edge, and both strobes may assert together.
- The counter never wraps: it clears on reaching STABLE_COUNT-1. Parameter combinations with STABLE_COUNT >= 2^CNT_WIDTH are illegal and must be flagged by a simulation-time check.
- Reset asserted mid-count: the count is discarded and outputs return to 0 immediately. After release, a raw input already held at 1 requires the full SYNC_STAGES + STABLE_COUNT edges to propagate.

Optional Feature:
Macro DEBOUNCE_FALL_PULSE_EN.
- Defined: adds output ports a_fall and b_fall (1 bit each). Each is a one-cycle registered strobe on a 1->0 output change, with the same timing as the rise strobes. Both reset to 0.
- Undefined: these ports and their logic do not exist, and the port list is exactly as above.

Test Plan:
All scenarios use STABLE_COUNT=4, SYNC_STAGES=2 and a 10 ns clk.
1. Reset, then btn_a_raw 0->1 sampled at edge E0 and held -> a=1 after E5, a_rise=1 for the cycle after E5 only, busy=1 from E2 to E5.
2. btn_b_raw pulses high for 3 cycles, then returns low -> b stays 0, b_rise never asserts, busy drops back to 0.
3. btn_a_raw bounces 1,0,1,0,1 on single cycles, then holds 1 -> a rises exactly 6 edges after the last 0->1 sample; one a_rise pulse total.
4. Both raw inputs go 0->1 on the same edge -> a and b rise on the same edge, a_rise and b_rise assert together, and the downstream NAND output goes 1->0 one cycle later in the combined bench.
5. rst asserted asynchronously mid-PENDING (counter=2), btn_a_raw held at 1 -> a, a_rise and busy are 0 immediately. After release, a=1 exactly 6 edges later.
6. With DEBOUNCE_FALL_PULSE_EN defined, a held at 1 and then btn_a_raw 1->0 held -> a=0 after 6 edges, a_fall is a one-cycle pulse, a_rise stays 0.
